pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Owns the architectural PC register and sequences instruction fetch for the RV32IMA pipeline IF stage.
- Selects next PC from sequential increment, EX-stage branch/JAL redirect or MEM-stage JALR redirect.
- Honours hazard-unit stalls and drives a req/ready handshake to instruction memory.
- Emits a one-cycle IF flush whenever the fetch stream is redirected.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
WATCHDOG_LIMIT, 4, consecutive unchanged-PC cycles that trip the hang flag (PC_WATCHDOG_EN only)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
pc_en_i  in  1  hazard unit: 1 = PC may advance, 0 = stall
redirect_ex_i  in  1  taken branch/JAL resolved in EX
target_ex_i  in  32  EX redirect target
redirect_mem_i  in  1  JALR resolved in MEM
target_mem_i  in  32  MEM redirect target
imem_ready_i  in  1  instruction memory accepts current request
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch address (= pc_reg_o)
pc_reg_o  out  32  architectural PC
instr_valid_o  out  1  accepted fetch is valid for IF/ID
if_flush_o  out  1  flush IF/ID register
misalign_o  out  1  redirect target had bits[1:0] != 0
pc_hang_o  out  1  sticky watchdog flag (0 when feature off)

Behaviour:
- Reset (async assert, sync release): pc_reg_o=RESET_PC, state=BOOT, all 1-bit outputs 0, pending register cleared.
- States: BOOT, FETCH, WAIT.
- BOOT: one cycle, no request, then FETCH.
- FETCH: imem_req_o = pc_en_i. Accept = imem_req_o && imem_ready_i.
  - Redirect present (MEM over EX when both high): pc <= target; if_flush_o=1 next cycle; instr_valid_o=0. If req && !ready, go WAIT with target in pending register; PC unchanged.
  - No redirect, accept: pc <= pc+4; instr_valid_o=1 same cycle.
  - No redirect, req && !ready: go WAIT, PC held.
  - pc_en_i=0, no redirect: PC held, no req.
- WAIT: imem_req_o=1, address stable regardless of pc_en_i or redirects.
  - Redirects update pending; MEM overwrites pending EX, EX never overwrites pending MEM.
  - On ready with pending: pc <= pending target, instr_valid_o=0, if_flush_o=1 next cycle, clear pending, go FETCH.
  - On ready without pending: pc <= pc+4, instr_valid_o=1, go FETCH.
- Target alignment: bits[1:0] forced to 00 on load. misalign_o pulses 1 cycle when the discarded bits were nonzero.
- Arithmetic: pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- imem_addr_o always equals pc_reg_o.
- Reset mid-WAIT drops the request and pending target immediately. No handshake completion is required.

Optional Feature:
PC_WATCHDOG_EN
- Defined: 3-bit counter increments each cycle pc_reg_o is unchanged and state != BOOT; clears on any change.
- Reaching WATCHDOG_LIMIT sets pc_hang_o, which stays set until reset.
- Undefined: counter absent; pc_hang_o tied 0.

Test Plan:
- Reset release, pc_en_i=1, imem_ready_i=1 -> BOOT 1 cycle, then pc_reg_o 0,4,8,C on consecutive cycles, instr_valid_o=1 each.
- pc_en_i=0 for 2 cycles at pc=8 -> imem_req_o=0, pc_reg_o holds 8, resumes 8->C.
- redirect_ex_i=1, target_ex_i=0x100, same cycle redirect_mem_i=1, target_mem_i=0x200 -> pc_reg_o=0x200, if_flush_o=1 next cycle, instr_valid_o=0.
- imem_ready_i=0 for 3 cycles at pc=0x10, redirect_ex_i to 0x40 in cycle 2 -> imem_addr_o stays 0x10; on ready, pc=0x40, flush pulse.
- Redirect target 0x103 -> pc_reg_o=0x100, misalign_o 1-cycle pulse; pc=0xFFFF_FFFC with accept -> 0x0.
- PC_WATCHDOG_EN, imem_ready_i=0 for 5 cycles -> pc_hang_o=1 after 4 unchanged cycles, stays 1 after ready returns.

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch port of the IF stage: request/address/ready handshake
// plus the "accepted fetch is valid" strobe towards IF/ID.
interface pc_fetch_ctrl_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i;
   logic        instr_valid_o;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      output instr_valid_o,
      input  imem_ready_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      input  instr_valid_o,
      output imem_ready_i
   );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// IF-stage PC owner and fetch sequencer: sequential / EX / MEM redirect selection,
// stall handling, imem handshake and redirect flush. Optional hang watchdog: PC_WATCHDOG_EN.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned WATCHDOG_LIMIT = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pc_en_i,
   input  logic                   redirect_ex_i,
   input  logic [31:0]            target_ex_i,
   input  logic                   redirect_mem_i,
   input  logic [31:0]            target_mem_i,
   pc_fetch_ctrl_if.master        imem,
   output logic [31:0]            pc_reg_o,
   output logic                   if_flush_o,
   output logic                   misalign_o,
   output logic                   pc_hang_o
);

   typedef enum logic [1:0] {S_BOOT, S_FETCH, S_WAIT} state_t;

   // The hang counter is 3 bits wide, so the limit must be reachable by it.
   if (WATCHDOG_LIMIT < 1 || WATCHDOG_LIMIT > 7) begin : g_bad_limit
      $error("WATCHDOG_LIMIT must be in 1..7");
   end

   state_t      state_q;
   logic [31:0] pc_q, pc_nxt, pc_inc, redirect_tgt;
   logic        redirect_any, accept;

   // Redirect target parked while a fetch is stuck waiting for imem_ready_i.
   logic        pend_v, pend_mem, pend_mis;
   logic [29:0] pend_t;
   logic        pend_v_nxt, pend_mem_nxt, pend_mis_nxt;
   logic [29:0] pend_t_nxt;

   assign redirect_any     = redirect_mem_i | redirect_ex_i;
   assign redirect_tgt     = redirect_mem_i ? target_mem_i : target_ex_i;
   assign pc_inc           = pc_q + 32'd4;
   assign accept           = imem.imem_req_o & imem.imem_ready_i;
   assign pc_reg_o         = pc_q;
   assign imem.imem_addr_o = pc_q;

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      pend_v_nxt   = pend_v;
      pend_t_nxt   = pend_t;
      pend_mem_nxt = pend_mem;
      pend_mis_nxt = pend_mis;
      if (state_q == S_WAIT) begin
         if (redirect_mem_i) begin
            pend_v_nxt   = 1'b1;
            pend_t_nxt   = target_mem_i[31:2];
            pend_mem_nxt = 1'b1;
            pend_mis_nxt = |target_mem_i[1:0];
         end else if (redirect_ex_i && !(pend_v && pend_mem)) begin
            pend_v_nxt   = 1'b1;
            pend_t_nxt   = target_ex_i[31:2];
            pend_mem_nxt = 1'b0;
            pend_mis_nxt = |target_ex_i[1:0];
         end
      end
   end

   always_comb begin
      imem.imem_req_o    = 1'b0;
      imem.instr_valid_o = 1'b0;
      pc_nxt             = pc_q;
      unique case (state_q)
         S_FETCH: begin
            imem.imem_req_o    = pc_en_i;
            imem.instr_valid_o = pc_en_i & imem.imem_ready_i & ~redirect_any;
            if (redirect_any && !(pc_en_i && !imem.imem_ready_i))
               pc_nxt = {redirect_tgt[31:2], 2'b00};
            else if (!redirect_any && pc_en_i && imem.imem_ready_i)
               pc_nxt = pc_inc;
         end
         S_WAIT: begin
            imem.imem_req_o    = 1'b1;
            imem.instr_valid_o = imem.imem_ready_i & ~pend_v_nxt;
            if (imem.imem_ready_i)
               pc_nxt = pend_v_nxt ? {pend_t_nxt, 2'b00} : pc_inc;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_BOOT;
         pc_q       <= RESET_PC;
         pend_v     <= 1'b0;
         pend_t     <= '0;
         pend_mem   <= 1'b0;
         pend_mis   <= 1'b0;
         if_flush_o <= 1'b0;
         misalign_o <= 1'b0;
      end else begin
         pc_q       <= pc_nxt;
         if_flush_o <= 1'b0;
         misalign_o <= 1'b0;
         unique case (state_q)
            S_BOOT: state_q <= S_FETCH;
            S_FETCH: begin
               if (imem.imem_req_o && !imem.imem_ready_i) begin
                  state_q  <= S_WAIT;
                  pend_v   <= redirect_any;
                  pend_t   <= redirect_tgt[31:2];
                  pend_mem <= redirect_mem_i;
                  pend_mis <= |redirect_tgt[1:0];
               end else if (redirect_any) begin
                  if_flush_o <= 1'b1;
                  misalign_o <= |redirect_tgt[1:0];
               end
            end
            S_WAIT: begin
               if (imem.imem_ready_i) begin
                  state_q    <= S_FETCH;
                  pend_v     <= 1'b0;
                  if_flush_o <= pend_v_nxt;
                  misalign_o <= pend_v_nxt & pend_mis_nxt;
               end else begin
                  pend_v   <= pend_v_nxt;
                  pend_t   <= pend_t_nxt;
                  pend_mem <= pend_mem_nxt;
                  pend_mis <= pend_mis_nxt;
               end
            end
            default: state_q <= S_BOOT;
         endcase
      end
   end

`ifdef PC_WATCHDOG_EN
   logic [2:0] wd_cnt;
   logic       hang_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_cnt <= '0;
         hang_q <= 1'b0;
      end else if (state_q != S_BOOT && pc_nxt == pc_q) begin
         if (wd_cnt != 3'd7) wd_cnt <= wd_cnt + 3'd1;
         if (32'(wd_cnt) + 32'd1 >= WATCHDOG_LIMIT) hang_q <= 1'b1;
      end else begin
         wd_cnt <= '0;
      end
   end

   assign pc_hang_o = hang_q;
`else
   assign pc_hang_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios, then random traffic,
// all compared cycle by cycle against a rule-level reference model.
module tb_pc_fetch_ctrl;

   localparam int unsigned LIMIT = 4;
`ifdef PC_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        pc_en_i, redirect_ex_i, redirect_mem_i;
   logic [31:0] target_ex_i, target_mem_i;
   logic [31:0] pc_reg_o;
   logic        if_flush_o, misalign_o, pc_hang_o;

   pc_fetch_ctrl_if bus ();

   pc_fetch_ctrl #(.RESET_PC(32'h0000_0000), .WATCHDOG_LIMIT(LIMIT)) dut (
      .clk            (clk),
      .reset          (reset),
      .pc_en_i        (pc_en_i),
      .redirect_ex_i  (redirect_ex_i),
      .target_ex_i    (target_ex_i),
      .redirect_mem_i (redirect_mem_i),
      .target_mem_i   (target_mem_i),
      .imem           (bus),
      .pc_reg_o       (pc_reg_o),
      .if_flush_o     (if_flush_o),
      .misalign_o     (misalign_o),
      .pc_hang_o      (pc_hang_o)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: what the fetch unit should look like, phrased as rules.
   logic [31:0] m_pc, m_pt;
   bit          m_boot, m_wait, m_pv, m_pmem, m_flush, m_mis, m_hang;
   int          m_unch;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_pt = 32'h0;
      m_boot = 1; m_wait = 0; m_pv = 0; m_pmem = 0;
      m_flush = 0; m_mis = 0; m_hang = 0; m_unch = 0;
   endtask

   task automatic step(input bit en, input bit rex, input logic [31:0] tex,
                       input bit rmem, input logic [31:0] tmem, input bit rdy);
      bit          req, valid, redir, pv, pmem, was_boot, nflush, nmis;
      logic [31:0] tgt, pt, npc;
      pc_en_i = en; redirect_ex_i = rex; target_ex_i = tex;
      redirect_mem_i = rmem; target_mem_i = tmem; bus.imem_ready_i = rdy;
      redir = rex | rmem;
      tgt   = rmem ? tmem : tex;
      // While waiting, a MEM redirect always wins; EX only if no MEM target is parked.
      pv = m_pv; pt = m_pt; pmem = m_pmem;
      if (m_wait) begin
         if (rmem) begin pv = 1; pt = tmem; pmem = 1; end
         else if (rex && !(m_pv && m_pmem)) begin pv = 1; pt = tex; pmem = 0; end
      end
      req = m_boot ? 1'b0 : (m_wait ? 1'b1 : en);
      if (m_boot)      valid = 0;
      else if (m_wait) valid = rdy && !pv;
      else             valid = req && rdy && !redir;

      @(negedge clk);
      chk("pc",       pc_reg_o,                m_pc);
      chk("addr",     bus.imem_addr_o,         m_pc);
      chk("req",      32'(bus.imem_req_o),     32'(req));
      chk("valid",    32'(bus.instr_valid_o),  32'(valid));
      chk("flush",    32'(if_flush_o),         32'(m_flush));
      chk("misalign", 32'(misalign_o),         32'(m_mis));
      chk("hang",     32'(pc_hang_o),          32'(WD_EN & m_hang));

      was_boot = m_boot;
      npc = m_pc; nflush = 0; nmis = 0;
      if (m_boot) begin
         m_boot = 0;
      end else if (m_wait) begin
         if (rdy) begin
            if (pv) begin npc = pt & ~32'h3; nflush = 1; nmis = (pt[1:0] != 2'b00); end
            else    npc = m_pc + 32'd4;
            m_wait = 0; m_pv = 0;
         end else begin
            m_pv = pv; m_pt = pt; m_pmem = pmem;
         end
      end else if (redir) begin
         if (req && !rdy) begin m_wait = 1; m_pv = 1; m_pt = tgt; m_pmem = rmem; end
         else begin npc = tgt & ~32'h3; nflush = 1; nmis = (tgt[1:0] != 2'b00); end
      end else if (req && rdy) begin
         npc = m_pc + 32'd4;
      end else if (req) begin
         m_wait = 1;
      end
      if (!was_boot && npc == m_pc) begin
         m_unch++;
         if (m_unch >= int'(LIMIT)) m_hang = 1;
      end else begin
         m_unch = 0;
      end
      m_pc = npc; m_flush = nflush; m_mis = nmis;
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b0;
      pc_en_i = 0; redirect_ex_i = 0; redirect_mem_i = 0;
      target_ex_i = '0; target_mem_i = '0; bus.imem_ready_i = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_pc",    pc_reg_o,               32'h0);
      chk("rst_req",   32'(bus.imem_req_o),    32'h0);
      chk("rst_valid", 32'(bus.instr_valid_o), 32'h0);
      chk("rst_flush", 32'(if_flush_o),        32'h0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Boot cycle, then sequential fetch 0,4,8 with a two-cycle stall at 8.
      step(1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      // Simultaneous EX and MEM redirect: MEM target wins.
      step(1, 1, 32'h100, 1, 32'h200, 1);
      step(1, 0, 0, 0, 0, 1);
      // Move to 0x10, then stall on imem with an EX redirect parked mid-wait.
      step(1, 1, 32'h10, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 32'h40, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      // A parked MEM target must survive a later EX redirect.
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 32'h80, 0);
      step(1, 1, 32'h44, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      // Misaligned targets, direct and parked.
      step(1, 1, 32'h103, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 1, 32'h302, 0);
      step(1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      // Wrap from the top of the address space.
      step(1, 1, 32'hFFFF_FFFC, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      // Long imem stall: trips the watchdog when enabled, which then stays set.
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1);

      // Reset asserted mid-wait drops the request and the parked target at once.
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 32'h500, 0, 0, 0);
      #2 reset = 1'b0;
      #1;
      chk("rstw_req",   32'(bus.imem_req_o), 32'h0);
      chk("rstw_pc",    pc_reg_o,            32'h0);
      chk("rstw_hang",  32'(pc_hang_o),      32'h0);
      model_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      step(1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);

      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom,
              $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 2) != 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
